// File: rtl/booth_radix4_controller_if.sv
// Control bundle between the radix-4 Booth controller (master) and its datapath (slave).
// Optional BOOTH_CTRL_CYCLE_COUNT_EN adds the cycle_count status field.
interface booth_radix4_controller_if;
  logic       START;
  logic [2:0] control;
  logic       shifter_HI_shift_enable;
  logic       shifter_HI_load_enable;
  logic       shifter_HI_clear;
  logic       shifter_LO_shift_enable;
  logic       shifter_LO_load_enable;
  logic       shifter_LO_clear;
  logic       register_M_enable;
  logic       register_M_clear;
  logic       register_X_enable;
  logic       register_X_clear;
  logic       adder_enable;
  logic [1:0] adder_mode;
  logic       READY;
  logic       DONE;
`ifdef BOOTH_CTRL_CYCLE_COUNT_EN
  logic [15:0] cycle_count;
`endif

  modport master (
    input  START, control,
    output shifter_HI_shift_enable, shifter_HI_load_enable, shifter_HI_clear,
           shifter_LO_shift_enable, shifter_LO_load_enable, shifter_LO_clear,
           register_M_enable, register_M_clear, register_X_enable, register_X_clear,
           adder_enable, adder_mode, READY, DONE
`ifdef BOOTH_CTRL_CYCLE_COUNT_EN
           , cycle_count
`endif
  );

  modport slave (
    output START, control,
    input  shifter_HI_shift_enable, shifter_HI_load_enable, shifter_HI_clear,
           shifter_LO_shift_enable, shifter_LO_load_enable, shifter_LO_clear,
           register_M_enable, register_M_clear, register_X_enable, register_X_clear,
           adder_enable, adder_mode, READY, DONE
`ifdef BOOTH_CTRL_CYCLE_COUNT_EN
           , cycle_count
`endif
  );
endinterface

// File: rtl/booth_radix4_controller.sv
// Moore controller sequencing a radix-4 Booth shift-and-add datapath.
// Define BOOTH_CTRL_CYCLE_COUNT_EN to add the INIT->DONE cycle_count status output.
module booth_radix4_controller #(
  parameter int unsigned size = 8
) (
  input logic                        CLOCK,
  input logic                        RESET,
  booth_radix4_controller_if.master  bus
);

  localparam int unsigned ITERS = size / 2;
  localparam int unsigned CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_DECODE, S_ADD, S_ACC, S_SHIFT, S_DONE
  } state_t;

  typedef struct packed {
    logic       hi_shift;
    logic       hi_load;
    logic       hi_clear;
    logic       lo_shift;
    logic       lo_load;
    logic       m_en;
    logic       x_en;
    logic       x_clear;
    logic       add_en;
    logic [1:0] add_mode;
    logic       ready;
    logic       done;
  } ctrl_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic [1:0]       passes_q, passes_d;
  ctrl_t            ctrl_q, ctrl_d;

  // State, iteration counter, op register and registered outputs
  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      neg_q        <= 1'b0;
      passes_q     <= 2'd0;
      ctrl_q       <= '0;
      ctrl_q.ready <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      passes_q <= passes_d;
      ctrl_q   <= ctrl_d;
    end
  end

  // Next state; a +-2M digit is executed as two +-M passes
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    passes_d = passes_q;
    unique case (state_q)
      S_IDLE: if (bus.START) state_d = S_INIT;
      S_INIT: begin
        cnt_d   = '0;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        unique case (bus.control)
          3'b001, 3'b010: begin neg_d = 1'b0; passes_d = 2'd1; end
          3'b011:         begin neg_d = 1'b0; passes_d = 2'd2; end
          3'b100:         begin neg_d = 1'b1; passes_d = 2'd2; end
          3'b101, 3'b110: begin neg_d = 1'b1; passes_d = 2'd1; end
          default:        begin neg_d = 1'b0; passes_d = 2'd0; end
        endcase
        state_d = (passes_d == 2'd0) ? S_SHIFT : S_ADD;
      end
      S_ADD: state_d = S_ACC;
      S_ACC: begin
        passes_d = passes_q - 2'd1;
        state_d  = (passes_q > 2'd1) ? S_ADD : S_SHIFT;
      end
      S_SHIFT: begin
        if (cnt_q == CNT_W'(ITERS - 1)) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_DECODE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode of the upcoming state so the registered outputs track the state
  always_comb begin
    ctrl_d = '0;
    unique case (state_d)
      S_IDLE: ctrl_d.ready = 1'b1;
      S_INIT: begin
        ctrl_d.m_en     = 1'b1;
        ctrl_d.lo_load  = 1'b1;
        ctrl_d.hi_clear = 1'b1;
        ctrl_d.x_clear  = 1'b1;
      end
      S_ADD: begin
        ctrl_d.add_en   = 1'b1;
        ctrl_d.add_mode = neg_d ? 2'b10 : 2'b01;
      end
      S_ACC: ctrl_d.hi_load = 1'b1;
      S_SHIFT: begin
        ctrl_d.hi_shift = 1'b1;
        ctrl_d.lo_shift = 1'b1;
        ctrl_d.x_en     = 1'b1;
      end
      S_DONE:  ctrl_d.done = 1'b1;
      default: ctrl_d = '0;
    endcase
  end

  assign bus.shifter_HI_shift_enable = ctrl_q.hi_shift;
  assign bus.shifter_HI_load_enable  = ctrl_q.hi_load;
  assign bus.shifter_HI_clear        = ctrl_q.hi_clear;
  assign bus.shifter_LO_shift_enable = ctrl_q.lo_shift;
  assign bus.shifter_LO_load_enable  = ctrl_q.lo_load;
  assign bus.shifter_LO_clear        = 1'b0;
  assign bus.register_M_enable       = ctrl_q.m_en;
  assign bus.register_M_clear        = 1'b0;
  assign bus.register_X_enable       = ctrl_q.x_en;
  assign bus.register_X_clear        = ctrl_q.x_clear;
  assign bus.adder_enable            = ctrl_q.add_en;
  assign bus.adder_mode              = ctrl_q.add_mode;
  assign bus.READY                   = ctrl_q.ready;
  assign bus.DONE                    = ctrl_q.done;

`ifdef BOOTH_CTRL_CYCLE_COUNT_EN
  logic [15:0] run_cnt_q, run_cnt_d;
  logic [15:0] cyc_cnt_q, cyc_cnt_d;
  logic [15:0] run_inc;

  // run_cnt counts INIT onward; the DONE cycle is added when the result is captured
  assign run_inc = (run_cnt_q == 16'hFFFF) ? run_cnt_q : run_cnt_q + 16'd1;

  always_comb begin
    run_cnt_d = run_cnt_q;
    cyc_cnt_d = cyc_cnt_q;
    unique case (state_q)
      S_INIT:                           run_cnt_d = 16'd1;
      S_DECODE, S_ADD, S_ACC, S_SHIFT:  run_cnt_d = run_inc;
      S_DONE:                           cyc_cnt_d = run_inc;
      default:                          run_cnt_d = run_cnt_q;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      run_cnt_q <= 16'd0;
      cyc_cnt_q <= 16'd0;
    end else begin
      run_cnt_q <= run_cnt_d;
      cyc_cnt_q <= cyc_cnt_d;
    end
  end

  assign bus.cycle_count = cyc_cnt_q;
`endif

endmodule

// File: tb/tb_booth_radix4_controller.sv
// Self-checking bench: controller driving a behavioural Booth datapath, scoreboarded products.
module tb_booth_radix4_controller;

  logic clk;
  logic rst_n;

  booth_radix4_controller_if bus();

  booth_radix4_controller #(.size(8)) dut (
    .CLOCK (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural datapath: HI carries two guard bits so +-M passes never overflow
  logic [7:0]        a_drv, b_drv;
  logic signed [9:0] hi_m, add_m, m_m;
  logic [7:0]        lo_m;
  logic              x_m;

  assign bus.control = {lo_m[1:0], x_m};

  always @(posedge clk) begin
    if (bus.register_M_enable) m_m <= {{2{b_drv[7]}}, b_drv};
    if (bus.shifter_LO_load_enable)       lo_m <= a_drv;
    else if (bus.shifter_LO_shift_enable) lo_m <= {hi_m[1:0], lo_m[7:2]};
    if (bus.shifter_HI_clear)             hi_m <= '0;
    else if (bus.shifter_HI_load_enable)  hi_m <= add_m;
    else if (bus.shifter_HI_shift_enable) hi_m <= hi_m >>> 2;
    if (bus.register_X_clear)             x_m <= 1'b0;
    else if (bus.register_X_enable)       x_m <= lo_m[1];
    if (bus.adder_enable) begin
      case (bus.adder_mode)
        2'b01:   add_m <= hi_m + m_m;
        2'b10:   add_m <= hi_m - m_m;
        default: add_m <= hi_m;
      endcase
    end
  end

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] s;
    int          lat;
    int          n_plus;
    int          n_minus;
  } vec_t;

  vec_t vecs[8];
  vec_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [10:0] enables();
    return {bus.shifter_HI_shift_enable, bus.shifter_HI_load_enable, bus.shifter_HI_clear,
            bus.shifter_LO_shift_enable, bus.shifter_LO_load_enable, bus.shifter_LO_clear,
            bus.register_M_enable, bus.register_M_clear, bus.register_X_enable,
            bus.register_X_clear, bus.adder_enable};
  endfunction

  // smode: 0 = START pulse, 1 = START toggles randomly mid-op, 2 = START held through DONE
  task automatic run_op(input int idx, input int smode);
    vec_t exp;
    int   cyc, n_plus, n_minus;
    bit   got, bad;
    @(negedge clk);
    chk($sformatf("ready_before_op%0d", idx), 32'(bus.READY), 32'd1);
    a_drv = vecs[idx].a;
    b_drv = vecs[idx].b;
    bus.START = 1'b1;
    sb.push_back(vecs[idx]);
    cyc = 0; n_plus = 0; n_minus = 0; got = 1'b0; bad = 1'b0;
    while (!got && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.adder_enable) begin
        if (bus.adder_mode == 2'b01)      n_plus++;
        else if (bus.adder_mode == 2'b10) n_minus++;
        else                              bad = 1'b1;
      end
      if (bus.shifter_HI_load_enable && bus.shifter_HI_shift_enable) bad = 1'b1;
      if (bus.shifter_LO_load_enable && bus.shifter_LO_shift_enable) bad = 1'b1;
      if (bus.shifter_LO_clear || bus.register_M_clear || bus.READY) bad = 1'b1;
      if (bus.DONE) begin
        got = 1'b1;
        if (smode != 2) bus.START = 1'b0;
      end else if (smode == 1) begin
        bus.START = 1'($urandom_range(0, 1));
      end else if (smode == 0) begin
        bus.START = 1'b0;
      end
    end
    chk($sformatf("done_seen_op%0d", idx), 32'(got), 32'd1);
    exp = sb.pop_front();
    chk($sformatf("latency_op%0d", idx), 32'(cyc), 32'(exp.lat));
    chk($sformatf("product_op%0d", idx), 32'({hi_m[7:0], lo_m}), 32'(exp.s));
    chk($sformatf("plus_passes_op%0d", idx), 32'(n_plus), 32'(exp.n_plus));
    chk($sformatf("minus_passes_op%0d", idx), 32'(n_minus), 32'(exp.n_minus));
    chk($sformatf("illegal_ctrl_op%0d", idx), 32'(bad), 32'd0);
    @(negedge clk);
    chk($sformatf("done_pulse_op%0d", idx), 32'({bus.DONE, bus.READY}), 32'b01);
    chk($sformatf("product_hold_op%0d", idx), 32'({hi_m[7:0], lo_m}), 32'(exp.s));
  endtask

  initial begin
    int n;
    vec_t exp;

    vecs[0] = '{a: 8'h00, b: 8'h05, s: 16'h0000, lat: 10, n_plus: 0, n_minus: 0};
    vecs[1] = '{a: 8'h01, b: 8'h03, s: 16'h0003, lat: 12, n_plus: 1, n_minus: 0};
    vecs[2] = '{a: 8'hFF, b: 8'h07, s: 16'hFFF9, lat: 12, n_plus: 0, n_minus: 1};
    vecs[3] = '{a: 8'h02, b: 8'h05, s: 16'h000A, lat: 16, n_plus: 1, n_minus: 2};
    vecs[4] = '{a: 8'h80, b: 8'h80, s: 16'h4000, lat: 14, n_plus: 0, n_minus: 2};
    vecs[5] = '{a: 8'h7F, b: 8'h81, s: 16'hC0FF, lat: 16, n_plus: 2, n_minus: 1};
    vecs[6] = '{a: 8'h55, b: 8'h03, s: 16'h00FF, lat: 18, n_plus: 4, n_minus: 0};
    vecs[7] = '{a: 8'hAA, b: 8'h7F, s: 16'hD556, lat: 20, n_plus: 0, n_minus: 5};

    rst_n = 1'b0;
    bus.START = 1'b0;
    a_drv = '0;
    b_drv = '0;
    repeat (3) @(negedge clk);
    chk("reset_enables", 32'(enables()), 32'd0);
    chk("reset_ready_done_mode", 32'({bus.READY, bus.DONE, bus.adder_mode}), 32'b1000);
`ifdef BOOTH_CTRL_CYCLE_COUNT_EN
    chk("reset_cycle_count", 32'(bus.cycle_count), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", 32'(bus.READY), 32'd1);

    for (int i = 0; i < 8; i++) begin
      run_op(i, (i == 4 || i == 6) ? 1 : 0);
`ifdef BOOTH_CTRL_CYCLE_COUNT_EN
      if (i == 3) chk("cycle_count_op3", 32'(bus.cycle_count), 32'd16);
`endif
    end

    // Reset while in ADD, then a clean operation
    @(negedge clk);
    a_drv = 8'h01;
    b_drv = 8'h03;
    bus.START = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      bus.START = 1'b0;
      n++;
    end while (!bus.adder_enable && n < 20);
    chk("reached_add", 32'(bus.adder_enable), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midop_reset_enables", 32'(enables()), 32'd0);
    chk("midop_reset_ready_done", 32'({bus.READY, bus.DONE, bus.adder_mode}), 32'b1000);
    run_op(1, 0);

    // START held high: second INIT two cycles after the first DONE
    run_op(1, 2);
    n = 1;
    while (!bus.register_M_enable && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_init_gap", 32'(n), 32'd2);
    bus.START = 1'b0;
    sb.push_back(vecs[1]);
    n = 1;
    while (!bus.DONE && n < 100) begin
      @(negedge clk);
      n++;
    end
    exp = sb.pop_front();
    chk("b2b_latency", 32'(n), 32'(exp.lat));
    chk("b2b_product", 32'({hi_m[7:0], lo_m}), 32'(exp.s));
    @(negedge clk);
    chk("b2b_idle", 32'({bus.DONE, bus.READY}), 32'b01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_radix4_controller.md
Name: booth_radix4_controller

Overview:
- Control unit for the radix-4 Booth shift-and-add multiplier datapath; sits directly upstream of it.
- Accepts a start request, sequences the datapath's load, add and shift enables from its 3-bit `control` feedback, and signals completion.
- Output pins connect one-to-one to the datapath's control inputs.
- Operands A (multiplier → LO) and B (multiplicand → M) are driven to the datapath directly, not through this block.

Parameters:
- `size`, default 8: operand width; must be even; iteration count is `size/2`.

Ports:
- `CLOCK`  in  1  single clock; all state changes on rising edge
- `RESET`  in  1  synchronous reset, active-low
- `START`  in  1  request a multiply; accepted only in IDLE
- `control`  in  3  datapath feedback: {LO[1:0], X}
- `shifter_HI_shift_enable`, `shifter_HI_load_enable`, `shifter_HI_clear`  out  1 each
- `shifter_LO_shift_enable`, `shifter_LO_load_enable`, `shifter_LO_clear`  out  1 each
- `register_M_enable`, `register_M_clear`, `register_X_enable`, `register_X_clear`  out  1 each
- `adder_enable`  out  1
- `adder_mode`  out  2  00 = HI+0, 01 = HI+M, 10 = HI−M, 11 never driven
- `READY`  out  1  high in IDLE
- `DONE`  out  1  one-cycle pulse; product valid on datapath S

Behaviour:
- Moore machine; all outputs decode from the registered state and op register.
- Reset (`RESET`=0 at a clock edge, any state, including mid-operation):
  - next state IDLE; iteration counter 0; op register 0.
  - Outputs: `READY`=1, everything else 0, `adder_mode`=00.
- States:
  - IDLE: `READY`=1. `START`=1 → INIT; otherwise stay.
  - INIT: `register_M_enable`=1, `shifter_LO_load_enable`=1, `shifter_HI_clear`=1, `register_X_clear`=1; counter ← 0. → DECODE.
  - DECODE: no enables. Latch op from `control`:
    - 000/111 → zero
    - 001/010 → +M, 1 pass
    - 011 → +M, 2 passes
    - 100 → −M, 2 passes
    - 101/110 → −M, 1 pass
    - Zero op → SHIFT; else → ADD.
  - ADD: `adder_enable`=1, `adder_mode` = 01 (+) or 10 (−). → ACC.
  - ACC: `shifter_HI_load_enable`=1; passes−1. Passes remaining → ADD; else → SHIFT.
  - SHIFT: `shifter_HI_shift_enable`=`shifter_LO_shift_enable`=`register_X_enable`=1.
    - counter == `size/2`−1 → DONE; else counter+1 → DECODE.
  - DONE: `DONE`=1 for exactly one cycle. → IDLE unconditionally.
- Cycles per iteration: zero op 2, ±M 4, ±2M 6.
- Latency: with `START` high in cycle 0, INIT occupies cycle 1 and `DONE` fires in cycle 2 + (sum of iteration cycles).
- `START` is ignored outside IDLE, including in the DONE cycle. Holding `START` high gives back-to-back operations with one IDLE cycle between them.
- S stays valid from DONE until the next INIT.
- ±2M is done as two sequential ±M passes; the datapath needs no 2M path.
- Never assert load and shift on the same shifter in the same cycle.
- `shifter_LO_clear` and `register_M_clear` stay 0 (reserved).

Optional Feature:
- Macro `BOOTH_CTRL_CYCLE_COUNT_EN`.
- Defined:
  - Adds output `cycle_count` [15:0] and an internal counter.
  - Counter clears in INIT and increments every cycle through DONE.
  - `cycle_count` holds the INIT→DONE cycle count of the last operation; 0 after reset.
  - Saturates at 16'hFFFF.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Latency counts `START` high in cycle 0. In each of the first four rows, `DONE` is a single-cycle pulse.
- `size`=8, A=0x00, B=5, `START` pulse → all four decodes are zero ops; `adder_enable` never asserted; `DONE` in cycle 10; S=0x0000.
- A=0x01, B=3 → `adder_mode`=01 exactly once; `DONE` in cycle 12; S=0x0003.
- A=0xFF, B=7 → first op −M (`adder_mode`=10 once), then three zero ops; `DONE` in cycle 12; S=0xFFF9.
- A=0x02, B=5 → first op −2M (two ADD/ACC pairs, mode 10), second op +M (mode 01), then two zero ops; `DONE` in cycle 16; S=0x000A.
- Drive `RESET`=0 for one edge while in ADD → next cycle all enables 0, `READY`=1, `DONE`=0. Then A=0x01, B=3 → S=0x0003 and `DONE` in cycle 12.
- `START` held high for two operations → second INIT starts exactly two cycles after the first `DONE`. `START` toggling mid-operation has no effect. With the macro defined, `cycle_count`=16 after the A=0x02, B=5 case.
